// File: rtl/ifid_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID instruction queue.
// The queue uses the slave modport; the fetch/decode side uses master.
interface ifid_queue_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    logic                    if_valid;
    logic [XLEN-1:0]         if_inst;
    logic [XLEN-1:0]         if_pc4;
    logic [TAG_W-1:0]        if_ins_type;
    logic [TAG_W-1:0]        if_ins_number;
    logic                    if_ready;
    logic                    id_stall;
    logic                    id_flush;
    logic                    id_valid;
    logic [XLEN-1:0]         id_inst;
    logic [XLEN-1:0]         id_pc4;
    logic [TAG_W-1:0]        id_ins_type;
    logic [TAG_W-1:0]        id_ins_number;
    logic [$clog2(DEPTH):0]  count;

    modport master (
        output if_valid, if_inst, if_pc4, if_ins_type, if_ins_number,
        output id_stall, id_flush,
        input  if_ready, id_valid, id_inst, id_pc4, id_ins_type, id_ins_number, count
    );

    modport slave (
        input  if_valid, if_inst, if_pc4, if_ins_type, if_ins_number,
        input  id_stall, id_flush,
        output if_ready, id_valid, id_inst, id_pc4, id_ins_type, id_ins_number, count
    );
endinterface

// File: rtl/ifid_queue.sv
// Circular instruction buffer between fetch and decode; presents a NOP
// bubble when empty, holds the head on stall and empties on flush.
module ifid_queue #(
    parameter int DEPTH     = 4,
    parameter int XLEN      = 32,
    parameter int TAG_W     = 4,
    parameter int NONE_TYPE = 0
) (
    input logic         clk,
    input logic         rst,
    ifid_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    typedef struct packed {
        logic [XLEN-1:0]  inst;
        logic [XLEN-1:0]  pc4;
        logic [TAG_W-1:0] ins_type;
        logic [TAG_W-1:0] ins_number;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count_q;
    logic [XLEN-1:0]  held_pc4;
    logic [TAG_W-1:0] held_num;
    logic             valid;
    logic             ready;
    logic             enq;
    logic             deq;

    always_comb begin
        valid = (count_q != '0);
        ready = (count_q != FULL);
        enq   = bus.if_valid && ready && !bus.id_flush;
        deq   = valid && !bus.id_stall && !bus.id_flush;
        head  = mem[rd_ptr];
    end

    // Storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= '{inst:       bus.if_inst,
                             pc4:        bus.if_pc4,
                             ins_type:   bus.if_ins_type,
                             ins_number: bus.if_ins_number};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
            held_pc4 <= '0;
            held_num <= '0;
        end else if (bus.id_flush) begin
            rd_ptr  <= wr_ptr;
            count_q <= '0;
            if (valid) begin
                held_pc4 <= head.pc4;
                held_num <= head.ins_number;
            end
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) begin
                rd_ptr   <= rd_ptr + 1'b1;
                held_pc4 <= head.pc4;
                held_num <= head.ins_number;
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        bus.if_ready      = ready;
        bus.count         = count_q;
        bus.id_valid      = valid;
        bus.id_inst       = valid ? head.inst       : '0;
        bus.id_pc4        = valid ? head.pc4        : held_pc4;
        bus.id_ins_type   = valid ? head.ins_type   : TAG_W'(NONE_TYPE);
        bus.id_ins_number = valid ? head.ins_number : held_num;
    end
endmodule
